// File: rtl/abp_frame_receiver_if.sv
// ---------------------------------------------------------------------------
// abp_frame_receiver_if
// Purpose : groups the byte-stream input and the payload output of the
//           alternating-bit frame receiver.
// Signals : s_axis_tvalid/tready/tlast/tdata - inbound frame byte stream
//           m_value/m_value_valid/m_value_ready - delivered payload handshake
// Modports: slave  - receiver side (sinks the stream, sources the payload)
//           master - environment side (sources the stream, sinks the payload)
// ---------------------------------------------------------------------------
interface abp_frame_receiver_if #(
  parameter int unsigned VALUE_BYTES = 8
);
  logic                       s_axis_tvalid;
  logic                       s_axis_tready;
  logic                       s_axis_tlast;
  logic [7:0]                 s_axis_tdata;
  logic [8*VALUE_BYTES-1:0]   m_value;
  logic                       m_value_valid;
  logic                       m_value_ready;

  modport slave (
    input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, m_value_ready,
    output s_axis_tready, m_value, m_value_valid
  );

  modport master (
    output s_axis_tvalid, s_axis_tlast, s_axis_tdata, m_value_ready,
    input  s_axis_tready, m_value, m_value_valid
  );
endinterface

// File: rtl/abp_frame_receiver.sv
// ---------------------------------------------------------------------------
// abp_frame_receiver
// Purpose : receives fixed-length frames over a byte stream, checks the
//           alternating bit (bit 0 of the final byte), acknowledges every
//           valid-length frame and delivers the payload of new frames only.
// Ports   : aclk, areset (async, active high)
//           bus          - abp_frame_receiver_if.slave (stream in, payload out)
//           ack_valid    - one-cycle acknowledge pulse
//           ack_bit      - alternating bit being acknowledged
//           expected_bit - alternating bit of the next new frame
//           busy         - high whenever the FSM is not idle
//           stat_frames/stat_dups/stat_errs - saturating counters, present
//           only when ABP_RX_STATS_EN is defined
// Macro   : ABP_RX_STATS_EN enables the statistics counters and their ports.
// ---------------------------------------------------------------------------
module abp_frame_receiver #(
  parameter int unsigned FRAME_BYTES = 64,
  parameter int unsigned VALUE_BYTES = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              aclk,
  input  logic              areset,
  abp_frame_receiver_if.slave bus,
  output logic              ack_valid,
  output logic              ack_bit,
  output logic              expected_bit,
  output logic              busy
`ifdef ABP_RX_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_frames,
  output logic [CNT_W-1:0]  stat_dups,
  output logic [CNT_W-1:0]  stat_errs
`endif
);

  localparam int unsigned IDX_W = $clog2(FRAME_BYTES);
  localparam int unsigned VAL_W = 8 * VALUE_BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    DROP    = 3'd2,
    CHECK   = 3'd3,
    DELIVER = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [VAL_W-1:0]   value_r, value_d;
  logic               last_bit, last_bit_d;
  logic               ack_valid_r, ack_valid_d;
  logic               ack_bit_r, ack_bit_d;
  logic               exp_r, exp_d;
  logic               mv_valid_r, mv_valid_d;
  logic               tready_r;
  logic               busy_r;
  logic               accept;

  assign accept = bus.s_axis_tvalid && tready_r;

  // State register plus all registered outputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      idx         <= '0;
      value_r     <= '0;
      last_bit    <= 1'b0;
      ack_valid_r <= 1'b0;
      ack_bit_r   <= 1'b0;
      exp_r       <= 1'b0;
      mv_valid_r  <= 1'b0;
      tready_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_d;
      value_r     <= value_d;
      last_bit    <= last_bit_d;
      ack_valid_r <= ack_valid_d;
      ack_bit_r   <= ack_bit_d;
      exp_r       <= exp_d;
      mv_valid_r  <= mv_valid_d;
      // tready/busy follow the state being entered so they match it exactly.
      tready_r    <= (state_nx != CHECK) && (state_nx != DELIVER);
      busy_r      <= (state_nx != IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) state_nx = bus.s_axis_tlast ? IDLE : RECV;
      end
      RECV: begin
        if (accept) begin
          if (idx == LAST_IDX)        state_nx = bus.s_axis_tlast ? CHECK : DROP;
          else if (bus.s_axis_tlast) state_nx = IDLE;
        end
      end
      DROP: begin
        if (accept && bus.s_axis_tlast) state_nx = IDLE;
      end
      CHECK: begin
        state_nx = (last_bit == exp_r) ? DELIVER : IDLE;
      end
      DELIVER: begin
        if (bus.m_value_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    idx_d       = idx;
    value_d     = value_r;
    last_bit_d  = last_bit;
    ack_valid_d = 1'b0;
    ack_bit_d   = ack_bit_r;
    exp_d       = exp_r;
    mv_valid_d  = mv_valid_r;

    // Capture payload bytes and the alternating bit while a frame is in flight.
    if (accept && ((state == IDLE) || (state == RECV))) begin
      for (int unsigned i = 0; i < VALUE_BYTES; i++) begin
        if (idx == IDX_W'(i)) value_d[8*i +: 8] = bus.s_axis_tdata;
      end
      if (idx == LAST_IDX) last_bit_d = bus.s_axis_tdata[0];
      idx_d = idx + 1'b1;
    end

    case (state)
      CHECK: begin
        ack_valid_d = 1'b1;
        ack_bit_d   = last_bit;
        if (last_bit == exp_r) begin
          exp_d      = ~exp_r;
          mv_valid_d = 1'b1;
        end
      end
      DELIVER: begin
        if (bus.m_value_ready) mv_valid_d = 1'b0;
      end
      default: ;
    endcase

    if (state_nx == IDLE) idx_d = '0;
  end

  assign bus.s_axis_tready = tready_r;
  assign bus.m_value       = value_r;
  assign bus.m_value_valid = mv_valid_r;
  assign ack_valid         = ack_valid_r;
  assign ack_bit           = ack_bit_r;
  assign expected_bit      = exp_r;
  assign busy              = busy_r;

`ifdef ABP_RX_STATS_EN
  logic             frame_inc, dup_inc, err_inc;
  logic [CNT_W-1:0] frames_r, dups_r, errs_r;

  assign frame_inc = (state == CHECK) && (last_bit == exp_r);
  assign dup_inc   = (state == CHECK) && (last_bit != exp_r);
  // Short frame (tlast before the last index) or end of an over-long frame.
  assign err_inc   = accept && bus.s_axis_tlast &&
                     ((state == IDLE) || (state == DROP) ||
                      ((state == RECV) && (idx != LAST_IDX)));

  // Saturating statistics counters.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      frames_r <= '0;
      dups_r   <= '0;
      errs_r   <= '0;
    end else begin
      if (frame_inc && (frames_r != '1)) frames_r <= frames_r + 1'b1;
      if (dup_inc   && (dups_r   != '1)) dups_r   <= dups_r + 1'b1;
      if (err_inc   && (errs_r   != '1)) errs_r   <= errs_r + 1'b1;
    end
  end

  assign stat_frames = frames_r;
  assign stat_dups   = dups_r;
  assign stat_errs   = errs_r;
`endif

endmodule

// File: tb/tb_abp_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_abp_frame_receiver
// Purpose : directed self-checking bench for abp_frame_receiver with default
//           parameters (64-byte frames, 8-byte payload, 16-bit counters).
//           Counter checks are compiled in only with ABP_RX_STATS_EN.
// ---------------------------------------------------------------------------
module tb_abp_frame_receiver;

  logic aclk   = 1'b0;
  logic areset = 1'b0;
  logic ack_valid, ack_bit, expected_bit, busy;
`ifdef ABP_RX_STATS_EN
  logic [15:0] stat_frames, stat_dups, stat_errs;
`endif

  abp_frame_receiver_if #(.VALUE_BYTES(8)) bus ();

  abp_frame_receiver #(
    .FRAME_BYTES(64),
    .VALUE_BYTES(8),
    .CNT_W(16)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .bus(bus),
    .ack_valid(ack_valid),
    .ack_bit(ack_bit),
    .expected_bit(expected_bit),
    .busy(busy)
`ifdef ABP_RX_STATS_EN
    ,
    .stat_frames(stat_frames),
    .stat_dups(stat_dups),
    .stat_errs(stat_errs)
`endif
  );

  always #5 aclk = ~aclk;

  int checks    = 0;
  int failures  = 0;
  int ack_cnt   = 0;
  int mv_cnt    = 0;
  int stall_cnt = 0;
  logic        last_ack_bit = 1'b0;
  logic [63:0] mv_capt      = '0;
  logic        mv_prev      = 1'b0;

  // Observe pulses on the falling edge, away from output updates.
  always @(negedge aclk) begin
    if (ack_valid) begin
      ack_cnt      <= ack_cnt + 1;
      last_ack_bit <= ack_bit;
    end
    if (bus.m_value_valid && !mv_prev) begin
      mv_cnt  <= mv_cnt + 1;
      mv_capt <= bus.m_value;
    end
    mv_prev <= bus.m_value_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time=%0t required=<200000", $time);
    $fatal(1, "watchdog");
  end

  // One beat; waits (bounded) for tready, returns at posedge+1 after acceptance.
  task automatic beat(input logic [7:0] d, input logic last);
    int waits;
    waits = 0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = last;
    while (bus.s_axis_tready !== 1'b1 && waits < 50) begin
      @(posedge aclk); #1;
      waits++;
    end
    if (waits != 0) stall_cnt++;
    @(posedge aclk); #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] last_val, input logic with_last);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) beat(last_val, with_last);
      else            beat(8'(i), 1'b0);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge aclk); #1;
    areset = 1'b1;
    #2;
    checks++; if (bus.s_axis_tready !== 1'b0) begin failures++; $display("FAIL reset_tready: got %b want 0", bus.s_axis_tready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus.m_value !== 64'h0) begin failures++; $display("FAIL reset_value: got %h want 0", bus.m_value); end
    checks++; if (bus.m_value_valid !== 1'b0 || ack_valid !== 1'b0 || ack_bit !== 1'b0) begin
      failures++; $display("FAIL reset_flags: mv=%b ack=%b ack_bit=%b want 0 0 0", bus.m_value_valid, ack_valid, ack_bit); end
    checks++; if (expected_bit !== 1'b0) begin failures++; $display("FAIL reset_expected: got %b want 0", expected_bit); end
`ifdef ABP_RX_STATS_EN
    checks++; if (stat_frames !== 16'd0 || stat_dups !== 16'd0 || stat_errs !== 16'd0) begin
      failures++; $display("FAIL reset_stats: got %0d %0d %0d want 0 0 0", stat_frames, stat_dups, stat_errs); end
`endif
    settle(2);
    areset = 1'b0;
    settle(1);
    checks++; if (bus.s_axis_tready !== 1'b1) begin failures++; $display("FAIL release_tready: got %b want 1", bus.s_axis_tready); end
  endtask

  task automatic test_valid_frame();
    int a0, m0, s0;
    a0 = ack_cnt; m0 = mv_cnt; s0 = stall_cnt;
    bus.m_value_ready = 1'b1;
    send_frame(64, 8'h3E, 1'b1);
    checks++; if (bus.s_axis_tready !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL check_state: tready=%b busy=%b want 0 1", bus.s_axis_tready, busy); end
    settle(6);
    checks++; if (ack_cnt - a0 != 1 || last_ack_bit !== 1'b0) begin
      failures++; $display("FAIL valid_ack: pulses=%0d bit=%b want 1 0", ack_cnt - a0, last_ack_bit); end
    checks++; if (mv_cnt - m0 != 1 || mv_capt !== 64'h0706050403020100) begin
      failures++; $display("FAIL valid_payload: deliveries=%0d value=%h want 1 0706050403020100", mv_cnt - m0, mv_capt); end
    checks++; if (expected_bit !== 1'b1 || stall_cnt != s0 || busy !== 1'b0) begin
      failures++; $display("FAIL valid_after: expected=%b stalls=%0d busy=%b want 1 0 0", expected_bit, stall_cnt - s0, busy); end
`ifdef ABP_RX_STATS_EN
    checks++; if (stat_frames !== 16'd1) begin failures++; $display("FAIL valid_frames: got %0d want 1", stat_frames); end
`endif
  endtask

  task automatic test_duplicate();
    int a0, m0;
    a0 = ack_cnt; m0 = mv_cnt;
    send_frame(64, 8'h3E, 1'b1);
    settle(6);
    checks++; if (ack_cnt - a0 != 1 || last_ack_bit !== 1'b0) begin
      failures++; $display("FAIL dup_ack: pulses=%0d bit=%b want 1 0", ack_cnt - a0, last_ack_bit); end
    checks++; if (mv_cnt != m0 || expected_bit !== 1'b1) begin
      failures++; $display("FAIL dup_no_payload: deliveries=%0d expected=%b want 0 1", mv_cnt - m0, expected_bit); end
`ifdef ABP_RX_STATS_EN
    checks++; if (stat_dups !== 16'd1) begin failures++; $display("FAIL dup_count: got %0d want 1", stat_dups); end
`endif
  endtask

  task automatic test_short_frame();
    int a0, m0;
    a0 = ack_cnt; m0 = mv_cnt;
    send_frame(10, 8'h09, 1'b1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL short_busy: got %b want 0", busy); end
    settle(4);
    checks++; if (ack_cnt != a0 || expected_bit !== 1'b1) begin
      failures++; $display("FAIL short_no_ack: pulses=%0d expected=%b want 0 1", ack_cnt - a0, expected_bit); end
`ifdef ABP_RX_STATS_EN
    checks++; if (stat_errs !== 16'd1) begin failures++; $display("FAIL short_errs: got %0d want 1", stat_errs); end
`endif
    send_frame(64, 8'h3F, 1'b1);
    settle(6);
    checks++; if (ack_cnt - a0 != 1 || last_ack_bit !== 1'b1) begin
      failures++; $display("FAIL after_short_ack: pulses=%0d bit=%b want 1 1", ack_cnt - a0, last_ack_bit); end
    checks++; if (mv_cnt - m0 != 1 || mv_capt !== 64'h0706050403020100 || expected_bit !== 1'b0) begin
      failures++; $display("FAIL after_short_payload: n=%0d value=%h expected=%b want 1 0706050403020100 0", mv_cnt - m0, mv_capt, expected_bit); end
`ifdef ABP_RX_STATS_EN
    checks++; if (stat_frames !== 16'd2) begin failures++; $display("FAIL after_short_frames: got %0d want 2", stat_frames); end
`endif
  endtask

  task automatic test_long_frame();
    int a0, s0;
    a0 = ack_cnt; s0 = stall_cnt;
    send_frame(70, 8'd69, 1'b1);
    checks++; if (stall_cnt != s0 || busy !== 1'b0) begin
      failures++; $display("FAIL long_tready: stalls=%0d busy=%b want 0 0", stall_cnt - s0, busy); end
    settle(4);
    checks++; if (ack_cnt != a0 || expected_bit !== 1'b0) begin
      failures++; $display("FAIL long_no_ack: pulses=%0d expected=%b want 0 0", ack_cnt - a0, expected_bit); end
`ifdef ABP_RX_STATS_EN
    checks++; if (stat_errs !== 16'd2) begin failures++; $display("FAIL long_errs: got %0d want 2", stat_errs); end
`endif
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    logic stable, low;
    int waits;
    bus.m_value_ready = 1'b0;
    send_frame(64, 8'h3E, 1'b1);
    waits = 0;
    while (bus.m_value_valid !== 1'b1 && waits < 5) begin
      @(posedge aclk); #1;
      waits++;
    end
    checks++; if (bus.m_value_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_timeout: got %b want 1", bus.m_value_valid); end
    held = bus.m_value; stable = 1'b1; low = 1'b1;
    repeat (5) begin
      @(posedge aclk); #1;
      if (bus.m_value !== held || bus.m_value_valid !== 1'b1) stable = 1'b0;
      if (bus.s_axis_tready !== 1'b0) low = 1'b0;
    end
    checks++; if (stable !== 1'b1 || held !== 64'h0706050403020100) begin
      failures++; $display("FAIL bp_hold: stable=%b value=%h want 1 0706050403020100", stable, held); end
    checks++; if (low !== 1'b1) begin failures++; $display("FAIL bp_tready: low=%b want 1", low); end
    bus.m_value_ready = 1'b1;
    @(posedge aclk); #1;
    checks++; if (bus.m_value_valid !== 1'b0 || busy !== 1'b0 || bus.s_axis_tready !== 1'b1) begin
      failures++; $display("FAIL bp_release: mv=%b busy=%b tready=%b want 0 0 1", bus.m_value_valid, busy, bus.s_axis_tready); end
    checks++; if (expected_bit !== 1'b1) begin failures++; $display("FAIL bp_expected: got %b want 1", expected_bit); end
`ifdef ABP_RX_STATS_EN
    checks++; if (stat_frames !== 16'd3 || stat_dups !== 16'd1 || stat_errs !== 16'd2) begin
      failures++; $display("FAIL bp_stats: got %0d %0d %0d want 3 1 2", stat_frames, stat_dups, stat_errs); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    int a0, m0;
    send_frame(20, 8'd19, 1'b0);
    #3;
    areset = 1'b1;
    #1;
    checks++; if (bus.s_axis_tready !== 1'b0 || busy !== 1'b0 || bus.m_value_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_ctrl: tready=%b busy=%b mv=%b want 0 0 0", bus.s_axis_tready, busy, bus.m_value_valid); end
    checks++; if (bus.m_value !== 64'h0 || ack_valid !== 1'b0 || ack_bit !== 1'b0 || expected_bit !== 1'b0) begin
      failures++; $display("FAIL midrst_data: value=%h ack=%b bit=%b exp=%b want 0 0 0 0", bus.m_value, ack_valid, ack_bit, expected_bit); end
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;
    checks++; if (bus.s_axis_tready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL midrst_resume: tready=%b busy=%b want 1 0", bus.s_axis_tready, busy); end
    a0 = ack_cnt; m0 = mv_cnt;
    send_frame(64, 8'h3E, 1'b1);
    settle(6);
    checks++; if (ack_cnt - a0 != 1 || last_ack_bit !== 1'b0 || mv_cnt - m0 != 1 || expected_bit !== 1'b1) begin
      failures++; $display("FAIL midrst_frame: pulses=%0d bit=%b deliveries=%0d exp=%b want 1 0 1 1", ack_cnt - a0, last_ack_bit, mv_cnt - m0, expected_bit); end
`ifdef ABP_RX_STATS_EN
    checks++; if (stat_frames !== 16'd1 || stat_dups !== 16'd0 || stat_errs !== 16'd0) begin
      failures++; $display("FAIL midrst_stats: got %0d %0d %0d want 1 0 0", stat_frames, stat_dups, stat_errs); end
`endif
  endtask

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tdata  = 8'h00;
    bus.m_value_ready = 1'b0;
    test_reset();
    test_valid_frame();
    test_duplicate();
    test_short_frame();
    test_long_frame();
    test_backpressure();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
